hazard_ctrl: RTL

Central pipeline sequencer for the 5-stage rv32 core. Generates per-stage stall/flush for IF, IF/ID and ID/EX (id_stage stall_i/flush_i) from load-use hazards, taken branches/jumps resolved in EX, data-memory wait and in-flight fetch draining. Holds a small FSM plus saturating performance counters and a memory-wait watchdog.

---
 rtl/rv32_pkg.sv | 36 +++
 rtl/sat_counter.sv | 26 ++
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared rv32 core types used by the pipeline hazard sequencer.
package rv32_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2
    } hazard_state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_stall;
        logic if_flush;
        logic id_stall;
        logic id_flush;
        logic ex_stall;
        logic pc_redirect;
    } hazard_ctrl_t;

    localparam logic [4:0] ZERO_REG = 5'd0;

    localparam hazard_ctrl_t CTRL_NONE     = '0;
    localparam hazard_ctrl_t CTRL_STALL    = '{pc_stall: 1'b1, if_stall: 1'b1, if_flush: 1'b0,
                                               id_stall: 1'b1, id_flush: 1'b0, ex_stall: 1'b1,
                                               pc_redirect: 1'b0};
    localparam hazard_ctrl_t CTRL_REDIRECT = '{pc_stall: 1'b0, if_stall: 1'b0, if_flush: 1'b1,
                                               id_stall: 1'b0, id_flush: 1'b1, ex_stall: 1'b0,
                                               pc_redirect: 1'b1};
    localparam hazard_ctrl_t CTRL_LOAD_USE = '{pc_stall: 1'b1, if_stall: 1'b1, if_flush: 1'b0,
                                               id_stall: 1'b0, id_flush: 1'b1, ex_stall: 1'b0,
                                               pc_redirect: 1'b0};
    localparam hazard_ctrl_t CTRL_DRAIN    = '{pc_stall: 1'b0, if_stall: 1'b0, if_flush: 1'b1,
                                               id_stall: 1'b0, id_flush: 1'b0, ex_stall: 1'b0,
                                               pc_redirect: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= '0;
        end else if (clr_i) begin
            r_q <= '0;
        end else if (inc_i && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q_o = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: per-stage stall/flush from load-use, EX redirects,
// data-memory wait and stale-fetch draining, plus perf counters and watchdog.
module hazard_ctrl
    import rv32_pkg::*;
#(
    parameter int          CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic             ex_valid_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_redirect_i,
    input  logic             imem_busy_i,
    input  logic             dmem_busy_i,
    output logic             pc_stall_o,
    output logic             if_stall_o,
    output logic             if_flush_o,
    output logic             id_stall_o,
    output logic             id_flush_o,
    output logic             ex_stall_o,
    output logic             pc_redirect_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    hazard_state_e r_state, w_eff_state, w_state_next;
    logic          r_drain_pending, w_drain_next;
    logic          r_timeout;
    hazard_ctrl_t  w_ctl, w_ctl_out;
    logic          w_redirect, w_load_use, w_flush_evt;
    logic          w_wd_inc, w_wd_hit;
    logic [WD_W-1:0] w_wd_cnt;

    assign w_redirect = ex_redirect_i & ex_valid_i;
    assign w_load_use = id_valid_i & ex_valid_i & ex_mem_read_i & (ex_rd_addr_i != ZERO_REG) &
                        ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                         (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));

    // Leaving MEM_WAIT takes effect in the same cycle: the resumed state's rules apply now.
    always_comb begin
        w_eff_state = r_state;
        if ((r_state == MEM_WAIT) && !dmem_busy_i) begin
            w_eff_state = (r_drain_pending && imem_busy_i) ? DRAIN : RUN;
        end
    end

    always_comb begin
        w_ctl        = CTRL_NONE;
        w_state_next = w_eff_state;
        w_drain_next = 1'b0;
        w_flush_evt  = 1'b0;
        unique case (w_eff_state)
            RUN: begin
                if (dmem_busy_i) begin
                    w_ctl        = CTRL_STALL;
                    w_state_next = MEM_WAIT;
                end else if (w_redirect) begin
                    w_ctl        = CTRL_REDIRECT;
                    w_flush_evt  = 1'b1;
                    w_state_next = imem_busy_i ? DRAIN : RUN;
                end else if (w_load_use) begin
                    w_ctl = CTRL_LOAD_USE;
                end
            end
            MEM_WAIT: begin
                w_ctl        = CTRL_STALL;
                w_drain_next = r_drain_pending;
            end
            DRAIN: begin
                if (dmem_busy_i) begin
                    w_ctl        = CTRL_STALL;
                    w_state_next = MEM_WAIT;
                    w_drain_next = 1'b1;
                end else if (w_redirect) begin
                    w_ctl        = CTRL_REDIRECT;
                    w_flush_evt  = 1'b1;
                    w_state_next = imem_busy_i ? DRAIN : RUN;
                end else begin
                    w_ctl        = CTRL_DRAIN;
                    w_state_next = imem_busy_i ? DRAIN : RUN;
                end
            end
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= RUN;
            r_drain_pending <= 1'b0;
            r_timeout       <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_drain_pending <= w_drain_next;
            if (w_wd_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // The watchdog reaches MEM_TIMEOUT on the edge that ends the qualifying cycle.
    assign w_wd_inc = (r_state == MEM_WAIT) && dmem_busy_i;
    assign w_wd_hit = w_wd_inc && (MEM_TIMEOUT != 0) &&
                      ((32'(w_wd_cnt) + 32'd1) >= MEM_TIMEOUT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (w_ctl.pc_stall),
        .clr_i  (1'b0),
        .q_o    (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (w_flush_evt),
        .clr_i  (1'b0),
        .q_o    (flush_cnt_o)
    );

    sat_counter #(.W(WD_W)) u_watchdog (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (w_wd_inc),
        .clr_i  (!w_wd_inc),
        .q_o    (w_wd_cnt)
    );

    // Reset forces the control outputs low immediately, not at the next edge.
    assign w_ctl_out     = rst_ni ? w_ctl : CTRL_NONE;
    assign pc_stall_o    = w_ctl_out.pc_stall;
    assign if_stall_o    = w_ctl_out.if_stall;
    assign if_flush_o    = w_ctl_out.if_flush;
    assign id_stall_o    = w_ctl_out.id_stall;
    assign id_flush_o    = w_ctl_out.id_flush;
    assign ex_stall_o    = w_ctl_out.ex_stall;
    assign pc_redirect_o = w_ctl_out.pc_redirect;
    assign timeout_o     = r_timeout;

endmodule
